// File: rtl/usb_rxparse.sv
// Walks a received USB packet in the rx RAM, checks header, block type, length and
// checksum, and streams the payload out on a valid/ready byte interface.
module usb_rxparse #(
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter logic [7:0]  HEAD      = 8'h55,
    parameter logic [11:0] MAX_LEN   = 12'd4000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fs_read_i,
    output logic        fd_read_o,
    input  logic [3:0]  read_btype_i,
    output logic [11:0] ram_rxa_o,
    input  logic [7:0]  ram_rxd_i,
    output logic [7:0]  dout_o,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic        dout_last_o,
    output logic [11:0] pkt_len_o,
    output logic [3:0]  stat_o,
    output logic        busy_o
);

    typedef enum logic [3:0] {
        StIdle, StHdr, StTyp, StLnh, StLnl, StDat, StOut, StChk, StAck
    } state_e;

    state_e      state_q;
    logic        cap_q;  // 0: address cycle, 1: capture cycle of the current byte
    logic [3:0]  btype_q;
    logic [3:0]  lenh_q;
    logic [11:0] len_q;
    logic [11:0] cnt_q;
    logic [7:0]  sum_q;
    logic [11:0] addr_q;
    logic        fd_read_q;
    logic [7:0]  dout_q;
    logic        valid_q;
    logic        last_q;
    logic [11:0] pkt_len_q;
    logic [3:0]  stat_q;
    logic [11:0] len_w;

    assign len_w = {lenh_q, ram_rxd_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cap_q     <= 1'b0;
            btype_q   <= 4'h0;
            lenh_q    <= 4'h0;
            len_q     <= 12'h000;
            cnt_q     <= 12'h000;
            sum_q     <= 8'h00;
            addr_q    <= BASE_ADDR;
            fd_read_q <= 1'b0;
            dout_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            pkt_len_q <= 12'h000;
            stat_q    <= 4'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fs_read_i && !fd_read_q) begin
                        stat_q  <= 4'h0;
                        btype_q <= read_btype_i;
                        addr_q  <= BASE_ADDR;
                        cap_q   <= 1'b0;
                        state_q <= StHdr;
                    end
                end
                StHdr: begin
                    cap_q <= ~cap_q;
                    if (cap_q) begin
                        addr_q <= addr_q + 12'd1;
                        if (ram_rxd_i != HEAD) begin
                            stat_q[0] <= 1'b1;
                            fd_read_q <= 1'b1;
                            state_q   <= StAck;
                        end else begin
                            state_q <= StTyp;
                        end
                    end
                end
                StTyp: begin
                    cap_q <= ~cap_q;
                    if (cap_q) begin
                        addr_q <= addr_q + 12'd1;
                        if (ram_rxd_i[3:0] != btype_q || ram_rxd_i[7:4] != 4'h0) begin
                            stat_q[1] <= 1'b1;
                            fd_read_q <= 1'b1;
                            state_q   <= StAck;
                        end else begin
                            state_q <= StLnh;
                        end
                    end
                end
                StLnh: begin
                    cap_q <= ~cap_q;
                    if (cap_q) begin
                        addr_q <= addr_q + 12'd1;
                        lenh_q <= ram_rxd_i[3:0];
                        if (ram_rxd_i[7:4] != 4'h0) begin
                            stat_q[2] <= 1'b1;
                            fd_read_q <= 1'b1;
                            state_q   <= StAck;
                        end else begin
                            state_q <= StLnl;
                        end
                    end
                end
                StLnl: begin
                    cap_q <= ~cap_q;
                    if (cap_q) begin
                        addr_q <= addr_q + 12'd1;
                        if (len_w == 12'h000 || len_w > MAX_LEN) begin
                            stat_q[2] <= 1'b1;
                            fd_read_q <= 1'b1;
                            state_q   <= StAck;
                        end else begin
                            pkt_len_q <= len_w;
                            len_q     <= len_w;
                            sum_q     <= 8'h00;
                            cnt_q     <= 12'h000;
                            state_q   <= StDat;
                        end
                    end
                end
                StDat: begin
                    cap_q <= ~cap_q;
                    if (cap_q) begin
                        dout_q  <= ram_rxd_i;
                        valid_q <= 1'b1;
                        last_q  <= (cnt_q == len_q - 12'd1);
                        sum_q   <= sum_q + ram_rxd_i;
                        state_q <= StOut;
                    end
                end
                StOut: begin
                    // Address only advances on accept, so a stalled sink freezes the RAM port.
                    if (dout_ready_i) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        addr_q  <= addr_q + 12'd1;
                        cnt_q   <= cnt_q + 12'd1;
                        state_q <= last_q ? StChk : StDat;
                    end
                end
                StChk: begin
                    cap_q <= ~cap_q;
                    if (cap_q) begin
                        if (ram_rxd_i != sum_q) begin
                            stat_q[3] <= 1'b1;
                        end
                        fd_read_q <= 1'b1;
                        state_q   <= StAck;
                    end
                end
                StAck: begin
                    if (!fs_read_i) begin
                        fd_read_q <= 1'b0;
                        addr_q    <= BASE_ADDR;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fd_read_o    = fd_read_q;
    assign ram_rxa_o    = addr_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;
    assign pkt_len_o    = pkt_len_q;
    assign stat_o       = stat_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_usb_rxparse.sv
// Scoreboard bench for usb_rxparse: a packet-level model predicts payload beats and the
// final status; a monitor compares them against the byte stream and the fd_read handshake.
module tb_usb_rxparse;

    localparam logic [11:0] BaseAddr = 12'h000;
    localparam logic [7:0]  Head     = 8'h55;
    localparam logic [11:0] MaxLen   = 12'd4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fs_read = 1'b0;
    logic        fd_read;
    logic [3:0]  read_btype = 4'h0;
    logic [11:0] ram_rxa;
    logic [7:0]  ram_rxd;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic [11:0] pkt_len;
    logic [3:0]  stat;
    logic        busy;

    always #5 clk = ~clk;

    usb_rxparse #(
        .BASE_ADDR(BaseAddr),
        .HEAD     (Head),
        .MAX_LEN  (MaxLen)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .fs_read_i   (fs_read),
        .fd_read_o   (fd_read),
        .read_btype_i(read_btype),
        .ram_rxa_o   (ram_rxa),
        .ram_rxd_i   (ram_rxd),
        .dout_o      (dout),
        .dout_valid_o(dout_valid),
        .dout_ready_i(dout_ready),
        .dout_last_o (dout_last),
        .pkt_len_o   (pkt_len),
        .stat_o      (stat),
        .busy_o      (busy)
    );

    // Synchronous RAM: data for the address of cycle N is visible in cycle N+1.
    logic [7:0] mem [4096];
    always @(posedge clk) ram_rxd <= mem[ram_rxa];

    typedef struct {
        logic [7:0]  d;
        logic        last;
        logic [11:0] a;
    } beat_t;

    typedef struct {
        logic [3:0]  st;
        logic [11:0] len;
    } res_t;

    beat_t      exp_q[$];
    res_t       res_q[$];
    int         errors = 0;
    int         checks = 0;
    int         model_len = 0;
    bit         rand_ready = 1'b0;
    int         stall_left = 0;
    logic [7:0] stall_val = 8'h00;
    int         stall_cycles = 0;
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: derive expected beats and status from the packet bytes in memory.
    task automatic model_packet(input logic [3:0] bt);
        int         len;
        logic [7:0] sum;
        logic [3:0] st;
        beat_t      b;
        res_t       r;
        st = 4'h0;
        if (mem[BaseAddr] !== Head) begin
            st = 4'b0001;
        end else if (mem[BaseAddr + 12'd1] !== {4'h0, bt}) begin
            st = 4'b0010;
        end else if (mem[BaseAddr + 12'd2] > 8'h0f) begin
            st = 4'b0100;
        end else begin
            len = int'(mem[BaseAddr + 12'd2]) * 256 + int'(mem[BaseAddr + 12'd3]);
            if (len == 0 || len > int'(MaxLen)) begin
                st = 4'b0100;
            end else begin
                model_len = len;
                sum = 8'h00;
                for (int i = 0; i < len; i++) begin
                    b.d    = mem[BaseAddr + 12'(4 + i)];
                    b.last = (i == len - 1);
                    b.a    = BaseAddr + 12'(4 + i);
                    sum    = sum + b.d;
                    exp_q.push_back(b);
                end
                if (sum !== mem[BaseAddr + 12'(4 + len)]) st = 4'b1000;
            end
        end
        r.st  = st;
        r.len = 12'(model_len);
        res_q.push_back(r);
    endtask

    // kind: 0 good, 1 bad head, 2 bad btype, 3 btype high nibble, 4 bad checksum, 5 byte2 high
    task automatic build(input int kind, input int len, input logic [3:0] bt);
        logic [7:0] sum;
        sum = 8'h00;
        mem[BaseAddr]         = Head;
        mem[BaseAddr + 12'd1] = {4'h0, bt};
        mem[BaseAddr + 12'd2] = {4'h0, 4'(len >> 8)};
        mem[BaseAddr + 12'd3] = 8'(len);
        for (int i = 0; i < len; i++) begin
            mem[BaseAddr + 12'(4 + i)] = 8'($urandom);
            sum = sum + mem[BaseAddr + 12'(4 + i)];
        end
        mem[BaseAddr + 12'(4 + len)] = sum;
        case (kind)
            1: mem[BaseAddr] = Head ^ 8'h01;
            2: mem[BaseAddr + 12'd1] = {4'h0, ~bt};
            3: mem[BaseAddr + 12'd1] = {4'h1, bt};
            4: mem[BaseAddr + 12'(4 + len)] = sum + 8'd1;
            5: mem[BaseAddr + 12'd2] = mem[BaseAddr + 12'd2] | 8'h10;
            default: ;
        endcase
    endtask

    task automatic load_basic(input logic [7:0] b0, input logic [7:0] b2, input logic [7:0] ck);
        mem[0] = b0;    mem[1] = 8'h03; mem[2] = b2;    mem[3] = 8'h04;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44; mem[8] = ck;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " fd_read"}, 32'(fd_read), 32'd0);
        check({tag, " ram_rxa"}, 32'(ram_rxa), 32'(BaseAddr));
        check({tag, " dout"}, 32'(dout), 32'd0);
        check({tag, " dout_valid"}, 32'(dout_valid), 32'd0);
        check({tag, " dout_last"}, 32'(dout_last), 32'd0);
        check({tag, " pkt_len"}, 32'(pkt_len), 32'd0);
        check({tag, " stat"}, 32'(stat), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_packet(input logic [3:0] bt, input bit early);
        int n;
        model_packet(bt);
        @(posedge clk); #1;
        fs_read    = 1'b1;
        read_btype = bt;
        @(posedge clk); #1;
        read_btype = ~bt;  // must have been latched on the start cycle
        if (early) fs_read = 1'b0;
        n = 0;
        while (fd_read !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("fd_read rise within budget", 32'(fd_read === 1'b1), 32'd1);
        if (fd_read !== 1'b1) begin
            fs_read = 1'b0;
            return;
        end
        if (early) begin
            @(negedge clk);
            check("fd_read single pulse after early drop", 32'(fd_read), 32'd0);
        end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("fd_read held while fs_read high", 32'(fd_read), 32'd1);
            @(posedge clk); #1;
            fs_read = 1'b0;
            @(negedge clk);
            check("fd_read before fs_read sampled low", 32'(fd_read), 32'd1);
            @(negedge clk);
            check("fd_read falls 1 clk after fs_read drop", 32'(fd_read), 32'd0);
        end
        check("busy back in idle", 32'(busy), 32'd0);
        check("ram_rxa back to base", 32'(ram_rxa), 32'(BaseAddr));
    endtask

    // Sink: ready either always, random, or forced low for a number of cycles on one byte value.
    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && dout_valid && dout == stall_val) begin
                dout_ready = 1'b0;
                stall_left--;
            end else begin
                dout_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Monitor: compares every presented beat and each packet completion against the model.
    initial begin
        beat_t b;
        res_t  r;
        logic  busy_prev;
        logic  fd_prev;
        int    t0;
        bit    armed;
        busy_prev = 1'b0;
        fd_prev   = 1'b0;
        t0        = 0;
        armed     = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (busy && !busy_prev) begin
                    armed = 1'b1;
                    t0    = cyc;
                end
                if (dout_valid) begin
                    if (armed) begin
                        check("first byte latency", 32'(cyc - t0), 32'd10);
                        armed = 1'b0;
                    end
                    if (!dout_ready) stall_cycles++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected dout: got %02h, expected no byte", dout);
                    end else begin
                        b = exp_q[0];
                        check("dout", 32'(dout), 32'(b.d));
                        check("dout_last", 32'(dout_last), 32'(b.last));
                        check("ram_rxa during OUT", 32'(ram_rxa), 32'(b.a));
                        if (dout_ready) void'(exp_q.pop_front());
                    end
                end
                if (fd_read && !fd_prev) begin
                    armed = 1'b0;
                    if (res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected fd_read: got 1, expected no packet");
                    end else begin
                        r = res_q.pop_front();
                        check("stat", 32'(stat), 32'(r.st));
                        check("pkt_len", 32'(pkt_len), 32'(r.len));
                        check("payload beats left at ack", 32'(exp_q.size()), 32'd0);
                        check("busy in ack", 32'(busy), 32'd1);
                    end
                end
            end
            busy_prev = busy;
            fd_prev   = fd_read;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        rst_n = 1'b1;

        // Basic packet, good checksum
        load_basic(8'h55, 8'h00, 8'hAA);
        run_packet(4'h3, 1'b0);
        // Bad header
        load_basic(8'h54, 8'h00, 8'hAA);
        run_packet(4'h3, 1'b0);
        // Bad checksum, payload still streamed
        load_basic(8'h55, 8'h00, 8'hAB);
        run_packet(4'h3, 1'b0);
        // Length errors: zero, high nibble in byte2, MAX_LEN+1
        build(0, 0, 4'h5);
        run_packet(4'h5, 1'b0);
        load_basic(8'h55, 8'h10, 8'hAA);
        run_packet(4'h3, 1'b0);
        build(0, int'(MaxLen) + 1, 4'h9);
        run_packet(4'h9, 1'b0);

        // Backpressure on byte 0x22
        load_basic(8'h55, 8'h00, 8'hAA);
        stall_cycles = 0;
        stall_val    = 8'h22;
        stall_left   = 7;
        run_packet(4'h3, 1'b0);
        check("stall cycles observed", 32'(stall_cycles), 32'd7);

        // Randomized packets with random backpressure and early fs_read drops
        rand_ready = 1'b1;
        for (int p = 0; p < 24; p++) begin
            int         k;
            int         len;
            logic [3:0] bt;
            k   = $urandom_range(0, 9);
            len = $urandom_range(1, 40);
            bt  = 4'($urandom);
            build((k > 5) ? 0 : k, len, bt);
            run_packet(bt, $urandom_range(0, 3) == 0);
        end
        rand_ready = 1'b0;

        // Largest legal packet
        build(0, int'(MaxLen), 4'hC);
        run_packet(4'hC, 1'b0);

        // Reset while stalled in OUT, then a clean packet
        load_basic(8'h55, 8'h00, 8'hAA);
        stall_val  = 8'h11;
        stall_left = 1000;
        model_packet(4'h3);
        @(posedge clk); #1;
        fs_read    = 1'b1;
        read_btype = 4'h3;
        n = 0;
        while (dout_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached OUT before reset", 32'(dout_valid), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        rst_n   = 1'b0;
        fs_read = 1'b0;
        exp_q.delete();
        res_q.delete();
        model_len  = 0;
        stall_left = 0;
        #1 check_reset_values("mid-packet reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_packet(4'h3, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size() + res_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
